// File: rtl/store_buffer.sv
// store_buffer: in-order store FIFO in front of a combinational-read memory, stalling loads that overlap any buffered store
// Ports:
//   clk_i, reset_ni                          clock, asynchronous active-low reset
//   st_valid_i/st_ready_o, st_addr_i,
//   st_data_i, st_size_i                     store request (data right-aligned)
//   ld_valid_i/ld_ready_o, ld_addr_i,
//   ld_size_i, ld_data_o                     load request, completes when ld_ready_o
//   mem_rd_addr_o/size_o, mem_rd_data_i      memory read port (combinational)
//   mem_wr_enable_o/ready_i, mem_wr_addr_o,
//   mem_wr_data_o, mem_wr_size_o             memory write port, driven from the head entry
//   occupancy_o, empty_o                     buffer fill status
module store_buffer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32
) (
   input  logic                     clk_i,
   input  logic                     reset_ni,
   input  logic                     st_valid_i,
   output logic                     st_ready_o,
   input  logic [ADDR_W-1:0]        st_addr_i,
   input  logic [31:0]              st_data_i,
   input  logic [1:0]               st_size_i,
   input  logic                     ld_valid_i,
   output logic                     ld_ready_o,
   input  logic [ADDR_W-1:0]        ld_addr_i,
   input  logic [1:0]               ld_size_i,
   output logic [31:0]              ld_data_o,
   output logic [ADDR_W-1:0]        mem_rd_addr_o,
   output logic [1:0]               mem_rd_size_o,
   input  logic [31:0]              mem_rd_data_i,
   output logic                     mem_wr_enable_o,
   input  logic                     mem_wr_ready_i,
   output logic [ADDR_W-1:0]        mem_wr_addr_o,
   output logic [31:0]              mem_wr_data_o,
   output logic [1:0]               mem_wr_size_o,
   output logic [$clog2(DEPTH):0]   occupancy_o,
   output logic                     empty_o
);
   localparam int PW  = $clog2(DEPTH);
   localparam int AW1 = ADDR_W + 1;
   logic [ADDR_W-1:0] r_addr [DEPTH];
   logic [31:0]       r_data [DEPTH];
   logic [1:0]        r_size [DEPTH];
   logic [PW-1:0]     r_head, r_tail;
   logic [PW:0]       r_count;
   logic              w_push, w_pop;
   logic [DEPTH-1:0]  w_hit;
   logic [AW1-1:0]    w_ld_lo, w_ld_hi;

   // the reserved size encoding is treated as a full word
   function automatic logic [2:0] nbytes(input logic [1:0] s);
      return s == 2'd0 ? 3'd1 : s == 2'd1 ? 3'd2 : 3'd4;
   endfunction

   assign st_ready_o      = r_count != (PW+1)'(DEPTH);
   assign mem_wr_enable_o = r_count != '0;
   assign w_push          = st_valid_i && st_ready_o;
   assign w_pop           = mem_wr_enable_o && mem_wr_ready_i;
   assign mem_wr_addr_o   = r_addr[r_head];
   assign mem_wr_data_o   = r_data[r_head];
   assign mem_wr_size_o   = r_size[r_head];
   assign occupancy_o     = r_count;
   assign empty_o         = r_count == '0;
   assign mem_rd_addr_o   = ld_addr_i;
   assign mem_rd_size_o   = ld_size_i;
   assign ld_data_o       = mem_rd_data_i;

   // byte ranges are compared one bit wider than the address so the end never wraps
   assign w_ld_lo = {1'b0, ld_addr_i};
   assign w_ld_hi = w_ld_lo + AW1'(nbytes(ld_size_i));

   // an entry is live when its distance from the head is below the count
   for (genvar g = 0; g < DEPTH; g++) begin : g_hz
      logic [PW-1:0]  w_off;
      logic [AW1-1:0] w_st_lo;
      assign w_off    = PW'(g) - r_head;
      assign w_st_lo  = {1'b0, r_addr[g]};
      assign w_hit[g] = ({1'b0, w_off} < r_count) && (w_st_lo < w_ld_hi) &&
                        (w_ld_lo < w_st_lo + AW1'(nbytes(r_size[g])));
   end

   assign ld_ready_o = ~|w_hit;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_tail <= r_tail + PW'(1);
         if (w_pop) r_head <= r_head + PW'(1);
         r_count <= w_push && !w_pop ? r_count + (PW+1)'(1) :
                    !w_push && w_pop ? r_count - (PW+1)'(1) : r_count;
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_addr[r_tail] <= st_addr_i;
         r_data[r_tail] <= st_data_i;
         r_size[r_tail] <= st_size_i;
      end
   end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: randomized and directed checks of store_buffer against a queue-based reference model
module tb_store_buffer;
   localparam int DEPTH = 4;
   localparam logic [1:0] BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2;

   logic        clk_i = 0, reset_ni = 0;
   logic        st_valid_i = 0, st_ready_o;
   logic [31:0] st_addr_i = 0, st_data_i = 0;
   logic [1:0]  st_size_i = 0;
   logic        ld_valid_i = 0, ld_ready_o;
   logic [31:0] ld_addr_i = 0, ld_data_o;
   logic [1:0]  ld_size_i = 0;
   logic [31:0] mem_rd_addr_o, mem_rd_data_i;
   logic [1:0]  mem_rd_size_o;
   logic        mem_wr_enable_o, mem_wr_ready_i = 1;
   logic [31:0] mem_wr_addr_o, mem_wr_data_o;
   logic [1:0]  mem_wr_size_o;
   logic [2:0]  occupancy_o;
   logic        empty_o;

   int n_vec = 0, n_err = 0;

   typedef struct { logic [31:0] a; logic [31:0] d; logic [1:0] s; } st_t;
   st_t q[$];
   logic [7:0] ref_mem [256];
   logic [7:0] sim_mem [256];

   store_buffer #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
      .clk_i(clk_i), .reset_ni(reset_ni),
      .st_valid_i(st_valid_i), .st_ready_o(st_ready_o), .st_addr_i(st_addr_i),
      .st_data_i(st_data_i), .st_size_i(st_size_i),
      .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o), .ld_addr_i(ld_addr_i),
      .ld_size_i(ld_size_i), .ld_data_o(ld_data_o),
      .mem_rd_addr_o(mem_rd_addr_o), .mem_rd_size_o(mem_rd_size_o), .mem_rd_data_i(mem_rd_data_i),
      .mem_wr_enable_o(mem_wr_enable_o), .mem_wr_ready_i(mem_wr_ready_i),
      .mem_wr_addr_o(mem_wr_addr_o), .mem_wr_data_o(mem_wr_data_o), .mem_wr_size_o(mem_wr_size_o),
      .occupancy_o(occupancy_o), .empty_o(empty_o)
   );

   always #5 clk_i = ~clk_i;

   // simple memory: little-endian, 256-byte aliased, zero-extended narrow reads
   always_comb begin
      mem_rd_data_i = {sim_mem[mem_rd_addr_o[7:0] + 8'd3], sim_mem[mem_rd_addr_o[7:0] + 8'd2],
                       sim_mem[mem_rd_addr_o[7:0] + 8'd1], sim_mem[mem_rd_addr_o[7:0]]};
      if (mem_rd_size_o == BYTE) mem_rd_data_i[31:8] = '0;
      else if (mem_rd_size_o == HALF) mem_rd_data_i[31:16] = '0;
   end

   function automatic int nb(input logic [1:0] s);
      return s == 2'd0 ? 1 : s == 2'd1 ? 2 : 4;
   endfunction

   function automatic bit m_ready(input logic [31:0] la, input logic [1:0] ls);
      longint lo, sa;
      lo = longint'(la);
      foreach (q[i]) begin
         sa = longint'(q[i].a);
         if (sa < lo + nb(ls) && lo < sa + nb(q[i].s)) return 0;
      end
      return 1;
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] la, input logic [1:0] ls);
      logic [31:0] d;
      d = 0;
      for (int k = 0; k < nb(ls); k++) d[8*k +: 8] = ref_mem[la[7:0] + 8'(k)];
      return d;
   endfunction

   // advance one clock: memory and reference model follow the accepted handshakes
   task automatic tick();
      bit push, pop, do_wr;
      st_t ns, wr;
      push  = st_valid_i && q.size() != DEPTH;
      pop   = q.size() != 0 && mem_wr_ready_i;
      do_wr = mem_wr_enable_o && mem_wr_ready_i;
      ns    = '{st_addr_i, st_data_i, st_size_i};
      wr    = '{mem_wr_addr_o, mem_wr_data_o, mem_wr_size_o};
      @(posedge clk_i);
      if (do_wr) for (int k = 0; k < nb(wr.s); k++) sim_mem[wr.a[7:0] + 8'(k)] = wr.d[8*k +: 8];
      if (pop) begin
         for (int k = 0; k < nb(q[0].s); k++) ref_mem[q[0].a[7:0] + 8'(k)] = q[0].d[8*k +: 8];
         void'(q.pop_front());
      end
      if (push) q.push_back(ns);
      #1;
   endtask

   task automatic idle(input logic rdy);
      st_valid_i = 0;
      ld_valid_i = 0;
      mem_wr_ready_i = rdy;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
      st_valid_i = 1;
      st_addr_i = a;
      st_data_i = d;
      st_size_i = s;
   endtask

   task automatic test_reset();
      reset_ni = 0;
      idle(1);
      repeat (2) @(posedge clk_i);
      #1;
      q.delete();
      n_vec += 4;
      if (st_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_st_ready got %b want 1", st_ready_o); end
      if (mem_wr_enable_o !== 1'b0) begin n_err++; $display("FAIL reset_wr_en got %b want 0", mem_wr_enable_o); end
      if (occupancy_o !== 3'd0) begin n_err++; $display("FAIL reset_occ got %0d want 0", occupancy_o); end
      if (empty_o !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", empty_o); end
      reset_ni = 1;
      tick();
   endtask

   task automatic test_single();
      store(32'h0001_0010, 32'hDEAD_BEEF, WORD);
      tick();
      idle(1);
      #1;
      n_vec += 5;
      if (mem_wr_enable_o !== 1'b1) begin n_err++; $display("FAIL single_wr_en got %b want 1", mem_wr_enable_o); end
      if (mem_wr_addr_o !== 32'h0001_0010) begin n_err++; $display("FAIL single_addr got %h want 00010010", mem_wr_addr_o); end
      if (mem_wr_data_o !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL single_data got %h want deadbeef", mem_wr_data_o); end
      if (mem_wr_size_o !== WORD) begin n_err++; $display("FAIL single_size got %0d want 2", mem_wr_size_o); end
      if (occupancy_o !== 3'd1) begin n_err++; $display("FAIL single_occ got %0d want 1", occupancy_o); end
      tick();
      n_vec++;
      if (empty_o !== 1'b1) begin n_err++; $display("FAIL single_empty got %b want 1", empty_o); end
   endtask

   task automatic test_fill();
      logic [31:0] ea [DEPTH], ed [DEPTH];
      mem_wr_ready_i = 0;
      for (int i = 0; i < DEPTH; i++) begin
         ea[i] = 32'h0001_0040 + 32'(4 * i);
         ed[i] = $urandom;
         store(ea[i], ed[i], WORD);
         #1;
         n_vec++;
         if (st_ready_o !== 1'b1) begin n_err++; $display("FAIL fill_ready%0d got %b want 1", i, st_ready_o); end
         tick();
      end
      store(32'h0001_0080, 32'h1234_5678, WORD);
      #1;
      n_vec += 2;
      if (occupancy_o !== 3'(DEPTH)) begin n_err++; $display("FAIL fill_occ got %0d want %0d", occupancy_o, DEPTH); end
      if (st_ready_o !== 1'b0) begin n_err++; $display("FAIL fill_full_ready got %b want 0", st_ready_o); end
      tick();
      idle(1);
      for (int i = 0; i < DEPTH; i++) begin
         #1;
         n_vec += 3;
         if (mem_wr_enable_o !== 1'b1) begin n_err++; $display("FAIL drain%0d_en got %b want 1", i, mem_wr_enable_o); end
         if (mem_wr_addr_o !== ea[i]) begin n_err++; $display("FAIL drain%0d_addr got %h want %h", i, mem_wr_addr_o, ea[i]); end
         if (mem_wr_data_o !== ed[i]) begin n_err++; $display("FAIL drain%0d_data got %h want %h", i, mem_wr_data_o, ed[i]); end
         tick();
      end
      #1;
      n_vec++;
      if (empty_o !== 1'b1) begin n_err++; $display("FAIL drain_empty got %b want 1", empty_o); end
   endtask

   task automatic test_hazard();
      logic [31:0] exp_d;
      mem_wr_ready_i = 0;
      store(32'h0001_0003, 32'h0000_00AB, BYTE);
      tick();
      idle(0);
      ld_valid_i = 1;
      ld_addr_i = 32'h0001_0000;
      ld_size_i = WORD;
      #1;
      n_vec++;
      if (ld_ready_o !== 1'b0) begin n_err++; $display("FAIL hazard_stall got %b want 0", ld_ready_o); end
      mem_wr_ready_i = 1;
      #1;
      n_vec++;
      if (ld_ready_o !== 1'b0) begin n_err++; $display("FAIL hazard_drain_cycle got %b want 0", ld_ready_o); end
      tick();
      #1;
      exp_d = m_read(32'h0001_0000, WORD);
      n_vec += 3;
      if (ld_ready_o !== 1'b1) begin n_err++; $display("FAIL hazard_release got %b want 1", ld_ready_o); end
      if (ld_data_o[31:24] !== 8'hAB) begin n_err++; $display("FAIL hazard_byte got %h want ab", ld_data_o[31:24]); end
      if (ld_data_o !== exp_d) begin n_err++; $display("FAIL hazard_data got %h want %h", ld_data_o, exp_d); end
      idle(1);
   endtask

   task automatic test_no_hazard();
      logic [31:0] exp_d;
      mem_wr_ready_i = 0;
      store(32'h0001_0004, $urandom, WORD);
      tick();
      idle(0);
      ld_valid_i = 1;
      ld_addr_i = 32'h0001_0000;
      ld_size_i = WORD;
      #1;
      exp_d = m_read(32'h0001_0000, WORD);
      n_vec += 2;
      if (ld_ready_o !== 1'b1) begin n_err++; $display("FAIL nohaz_ready got %b want 1", ld_ready_o); end
      if (ld_data_o !== exp_d) begin n_err++; $display("FAIL nohaz_data got %h want %h", ld_data_o, exp_d); end
      ld_addr_i = 32'h0001_0002;
      ld_size_i = HALF;
      #1;
      n_vec++;
      if (ld_ready_o !== 1'b1) begin n_err++; $display("FAIL edge_below got %b want 1", ld_ready_o); end
      ld_addr_i = 32'h0001_0003;
      #1;
      n_vec++;
      if (ld_ready_o !== 1'b0) begin n_err++; $display("FAIL edge_touch got %b want 0", ld_ready_o); end
      ld_addr_i = 32'h0001_0008;
      ld_size_i = 2'd3;
      #1;
      n_vec++;
      if (ld_ready_o !== 1'b1) begin n_err++; $display("FAIL edge_above got %b want 1", ld_ready_o); end
      idle(1);
      tick();
   endtask

   task automatic test_simul();
      mem_wr_ready_i = 0;
      store(32'h0001_0020, $urandom, WORD);
      tick();
      store(32'h0001_0024, $urandom, HALF);
      tick();
      mem_wr_ready_i = 1;
      store(32'h0001_0028, $urandom, BYTE);
      #1;
      n_vec++;
      if (occupancy_o !== 3'd2) begin n_err++; $display("FAIL simul_before got %0d want 2", occupancy_o); end
      tick();
      idle(1);
      #1;
      n_vec++;
      if (occupancy_o !== 3'd2) begin n_err++; $display("FAIL simul_after got %0d want 2", occupancy_o); end
      repeat (2) tick();
   endtask

   task automatic test_random();
      logic [31:0] exp_d;
      for (int c = 0; c < 300; c++) begin
         st_valid_i = ($urandom_range(0, 99) < 55);
         st_addr_i = 32'h0001_0000 + 32'($urandom_range(0, 23));
         st_data_i = $urandom;
         st_size_i = 2'($urandom_range(0, 3));
         ld_valid_i = $urandom_range(0, 1) == 1;
         ld_addr_i = 32'h0001_0000 + 32'($urandom_range(0, 23));
         ld_size_i = 2'($urandom_range(0, 3));
         mem_wr_ready_i = ($urandom_range(0, 99) < 60);
         #1;
         n_vec += 5;
         if (st_ready_o !== (q.size() != DEPTH)) begin n_err++; $display("FAIL rnd%0d_st_ready got %b", c, st_ready_o); end
         if (mem_wr_enable_o !== (q.size() != 0)) begin n_err++; $display("FAIL rnd%0d_wr_en got %b", c, mem_wr_enable_o); end
         if (occupancy_o !== 3'(q.size())) begin n_err++; $display("FAIL rnd%0d_occ got %0d want %0d", c, occupancy_o, q.size()); end
         if (ld_ready_o !== m_ready(ld_addr_i, ld_size_i)) begin n_err++; $display("FAIL rnd%0d_ld_ready got %b want %b", c, ld_ready_o, m_ready(ld_addr_i, ld_size_i)); end
         if (mem_rd_addr_o !== ld_addr_i || mem_rd_size_o !== ld_size_i) begin n_err++; $display("FAIL rnd%0d_rd_port got %h/%0d want %h/%0d", c, mem_rd_addr_o, mem_rd_size_o, ld_addr_i, ld_size_i); end
         if (q.size() != 0) begin
            n_vec++;
            if ({mem_wr_addr_o, mem_wr_data_o, mem_wr_size_o} !== {q[0].a, q[0].d, q[0].s}) begin
               n_err++;
               $display("FAIL rnd%0d_head got %h/%h/%0d want %h/%h/%0d", c, mem_wr_addr_o, mem_wr_data_o, mem_wr_size_o, q[0].a, q[0].d, q[0].s);
            end
         end
         if (m_ready(ld_addr_i, ld_size_i)) begin
            exp_d = m_read(ld_addr_i, ld_size_i);
            n_vec++;
            if (ld_data_o !== exp_d) begin n_err++; $display("FAIL rnd%0d_ld_data got %h want %h", c, ld_data_o, exp_d); end
         end
         tick();
      end
      idle(1);
      repeat (DEPTH + 1) tick();
   endtask

   task automatic test_async_reset();
      mem_wr_ready_i = 0;
      for (int i = 0; i < 3; i++) begin
         store(32'h0001_0030 + 32'(4 * i), $urandom, WORD);
         tick();
      end
      idle(0);
      #2;
      reset_ni = 0;
      #1;
      n_vec += 4;
      if (mem_wr_enable_o !== 1'b0) begin n_err++; $display("FAIL areset_wr_en got %b want 0", mem_wr_enable_o); end
      if (empty_o !== 1'b1) begin n_err++; $display("FAIL areset_empty got %b want 1", empty_o); end
      if (st_ready_o !== 1'b1) begin n_err++; $display("FAIL areset_st_ready got %b want 1", st_ready_o); end
      if (occupancy_o !== 3'd0) begin n_err++; $display("FAIL areset_occ got %0d want 0", occupancy_o); end
      q.delete();
      #1;
      reset_ni = 1;
      mem_wr_ready_i = 1;
      tick();
      n_vec++;
      if (mem_wr_enable_o !== 1'b0) begin n_err++; $display("FAIL areset_after got %b want 0", mem_wr_enable_o); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         ref_mem[i] = 8'($urandom);
         sim_mem[i] = ref_mem[i];
      end
      test_reset();
      test_single();
      test_fill();
      test_hazard();
      test_no_hazard();
      test_simul();
      test_random();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Sits directly upstream of the byte-addressed simple memory array, between the core's load/store unit and the mem_array_if fields.
- Buffers stores in a FIFO and drains them in order to the memory write port, one per accepted cycle.
- Passes loads straight through to the combinational read port.
- Stalls a load only while a buffered store overlaps any byte the load reads.

Parameters:
- DEPTH, 4, number of store entries; power of two, at least 2.
- ADDR_W, 32, address width.

Ports:
- clk_i  in  1  clock.
- reset_ni  in  1  asynchronous active-low reset.
- st_valid_i  in  1  store request valid.
- st_ready_o  out  1  store accepted when st_valid_i && st_ready_o.
- st_addr_i  in  ADDR_W  store byte address.
- st_data_i  in  32  store data, right-aligned.
- st_size_i  in  2  mem_access_size_t (MEM_ACCESS_SIZE_BYTE/HALF/WORD).
- ld_valid_i  in  1  load request valid.
- ld_ready_o  out  1  load completes this cycle when ld_valid_i && ld_ready_o.
- ld_addr_i  in  ADDR_W  load byte address.
- ld_size_i  in  2  mem_access_size_t.
- ld_data_o  out  32  load data, valid when ld_ready_o.
- mem_rd_addr_o  out  ADDR_W  to memif.rd_addr.
- mem_rd_size_o  out  2  to memif.rd_size.
- mem_rd_data_i  in  32  from memif.rd_data, combinational.
- mem_wr_enable_o  out  1  to memif.wr_enable.
- mem_wr_ready_i  in  1  memory accepts the write this cycle; tie to 1 for the simple memory.
- mem_wr_addr_o  out  ADDR_W  to memif.wr_addr.
- mem_wr_data_o  out  32  to memif.wr_data.
- mem_wr_size_o  out  2  to memif.wr_size.
- occupancy_o  out  $clog2(DEPTH)+1  entries held.
- empty_o  out  1  occupancy_o == 0.

Behaviour:
- Clocking and reset: single clock domain. reset_ni is asynchronous and active-low.
- Reset state:
  - head pointer, tail pointer and count = 0; entry contents are not reset.
  - Outputs: st_ready_o=1, mem_wr_enable_o=0, occupancy_o=0, empty_o=1.
  - Asserting reset mid-operation discards all pending stores immediately; no partial drain.
- Enqueue:
  - st_ready_o = (count != DEPTH). Depends on state only; no full-bypass.
  - On an accepted store, write {addr, data, size} at the tail and advance the tail, wrapping at DEPTH.
- Drain:
  - mem_wr_enable_o = (count != 0).
  - mem_wr_addr_o, mem_wr_data_o and mem_wr_size_o are driven from the head entry registers.
  - On mem_wr_enable_o && mem_wr_ready_i, advance the head, wrapping at DEPTH.
  - A store accepted at edge N first appears on the write port in cycle N+1. Minimum store-to-memory latency is 1 cycle.
- Count update:
  - Enqueue only: +1. Dequeue only: -1. Both in the same cycle: unchanged.
  - count never exceeds DEPTH and never underflows.
- Load path (combinational):
  - mem_rd_addr_o = ld_addr_i, mem_rd_size_o = ld_size_i, ld_data_o = mem_rd_data_i.
- Hazard check:
  - Byte counts: BYTE=1, HALF=2, WORD=4. The reserved encoding counts as 4.
  - A store S and load L overlap iff S.addr < L.addr + Lbytes && L.addr < S.addr + Sbytes. Evaluate at ADDR_W+1 bits so there is no wrap-around.
  - The check covers every valid entry, including the head being drained this cycle.
  - ld_ready_o = !(any overlap); it is 1 whenever the buffer is empty.
  - ld_ready_o is evaluated even when ld_valid_i=0.
- Ordering:
  - A load and a store accepted in the same cycle: the load is ordered first and returns pre-store memory contents.
  - Stores drain strictly in acceptance order.
- No alignment checks are made. Addresses and sizes pass through unchanged.

Test Plan:
1. Reset, then store WORD 0x00010010 / 0xDEADBEEF with mem_wr_ready_i=1 -> next cycle mem_wr_enable_o=1, addr 0x00010010, data 0xDEADBEEF, size WORD; the following cycle empty_o=1.
2. mem_wr_ready_i=0, issue DEPTH stores back-to-back -> occupancy_o reaches 4 and st_ready_o=0. Release ready -> four writes drain in order on consecutive cycles.
3. Hold a pending BYTE store 0xAB at 0x00010003 (mem_wr_ready_i=0), then load WORD at 0x00010000 -> ld_ready_o=0. Set ready=1 -> ld_ready_o=1 one cycle after the drain, with ld_data_o[31:24]=0xAB.
4. Pending WORD store at 0x00010004, load WORD at 0x00010000 -> ld_ready_o=1 in the same cycle, with data equal to memory contents.
5. At occupancy 2 with mem_wr_ready_i=1, accept a store and a drain in the same cycle -> occupancy stays 2. Pointers wrap correctly across 3×DEPTH stores.
6. With 3 pending stores, drive reset_ni low mid-cycle -> mem_wr_enable_o=0, empty_o=1 and st_ready_o=1 asynchronously, before the next clock edge.
